regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports r0_valid/r0_ready  input/output  1/1  execute-stage write request handshake.
REQ-006 SHALL have ports r0_addr/r0_data  input/input  ADDR_W/DATA_W  execute-stage destination and value.
REQ-007 SHALL have ports r1_valid/r1_ready  input/output  1/1  load-return (bus) write request handshake.
REQ-008 SHALL have ports r1_addr/r1_data  input/input  ADDR_W/DATA_W  load destination and value.
REQ-009 SHALL have ports we3/a3/wd3  output  1/ADDR_W/DATA_W  registered drive of the register-file write port.
REQ-010 SHALL have ports a1/a2  input  ADDR_W  current read addresses of the register file.
REQ-011 SHALL have ports hz1/hz2  output  1  pending-write hazard flags for a1/a2.
REQ-012 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-013 SHALL hold one entry (held_k, addr_k, data_k) per requester k; rk_ready = ~held_k & ~busy, combinational from state only.
REQ-014 SHALL accept on rk_valid & rk_ready at an edge; addr != 0 sets held_k and captures addr/data; addr == 0 is accepted and discarded (never written).
REQ-015 SHALL, when not busy, grant at most one held entry per edge: on grant, we3<=1, a3<=addr_k, wd3<=data_k, held_k<=0; with no grant, we3<=0 and a3/wd3 keep their values.
REQ-016 SHALL have latency: accept at edge N -> we3=1 during cycle after edge N+1 (earliest grant at N+1) -> register file writes at edge N+2.
REQ-017 SHALL arbitrate round-robin with a priority pointer: both held -> grant pointer side; after any grant the pointer moves to the non-granted requester.
REQ-018 SHALL override round-robin when both held with equal addr: grant the earlier-accepted entry; if both were accepted at the same edge, grant r0 first so the load value is written last.
REQ-019 SHALL drive hzX = (aX != 0) & ((held_0 & addr_0 == aX) | (held_1 & addr_1 == aX) | (we3 & a3 == aX)), combinational.
REQ-020 SHALL allow one requester to accept again only in the cycle after its entry is granted (rk_ready low in the grant cycle).

Reset
REQ-021 SHALL on resetn low, asynchronously: we3=0, a3=0, wd3=0, held_0=held_1=0, pointer=r0, age state cleared.
REQ-022 SHALL discard any held entry if reset asserts mid-operation; no partial write is issued after reset release.
REQ-023 SHALL give r0_ready/r1_ready reset value ~busy (busy per REQ-025/026).

Configuration
REQ-024 SHALL compile the clear sequencer only when REGFILE_CLEAR_EN is defined.
REQ-025 SHALL, with REGFILE_CLEAR_EN: busy resets to 1; a 5-bit counter resets to 1; each edge after release drives we3=1, a3=counter, wd3=0, then increments; after writing x31 the next edge gives busy=0, we3=0; exactly 31 writes, no requests accepted meanwhile.
REQ-026 SHALL, without REGFILE_CLEAR_EN: busy is constant 0, no counter exists, and requests are accepted from the first edge after reset release.

Verification
REQ-027 SHALL cover clear: with REGFILE_CLEAR_EN, release reset -> we3=1 for 31 consecutive cycles, a3 = 1..31, wd3=0, busy falls the cycle after a3=31, ready rises with it.
REQ-028 SHALL cover single write: r0 addr=5 data=0xDEADBEEF accepted at edge N -> we3=1, a3=5, wd3=0xDEADBEEF after N+1; hz1=1 while a1=5 from N until write issue ends.
REQ-029 SHALL cover contention: r0 (addr 3) and r1 (addr 4) held together, pointer=r0 -> a3=3 then a3=4 on consecutive cycles; repeat with pointer=r1 -> order 4 then 3.
REQ-030 SHALL cover same-address ordering: r0 and r1 both addr 7, accepted same edge, r0 data=1, r1 data=2 -> writes 1 then 2; r1 accepted one edge earlier -> writes 2 then 1.
REQ-031 SHALL cover x0 and reset: r1 addr=0 -> r1 accepted, no we3 pulse, hz flags 0; resetn low while both entries are held -> no we3 after release except clear writes.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two single-entry request buffers (execute
// result r0, load return r1) share one registered write port (we3/a3/wd3).
// Round-robin between requesters, except that same-address writes retire in
// acceptance order. hz1/hz2 flag reads whose register has a write still in flight.
// Optional feature: define REGFILE_CLEAR_EN to zero registers x1..x31 after reset.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic              hz1,
  output logic              hz2,
  output logic              busy
);

  logic              held0_q, held1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic              ptr_q;       // 0: r0 has priority, 1: r1 has priority
  logic              r1_older_q;  // r1 entry accepted strictly before r0 entry
  logic              set0, set1;
  logic              gnt0, gnt1;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              we3_d;
  logic [ADDR_W-1:0] a3_d;
  logic [DATA_W-1:0] wd3_d;

`ifdef REGFILE_CLEAR_EN
  logic       busy_q;
  logic [4:0] clr_cnt_q;

  // Clear sequencer: counter walks 1..31, wraps to 0, and that edge ends the sequence
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q    <= 1'b1;
      clr_cnt_q <= 5'd1;
    end else if (busy_q) begin
      if (clr_cnt_q == 5'd0) begin
        busy_q <= 1'b0;
      end else begin
        clr_cnt_q <= clr_cnt_q + 5'd1;
      end
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q & (clr_cnt_q != 5'd0);
  assign clr_addr = ADDR_W'(clr_cnt_q);
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign r0_ready = ~held0_q & ~busy;
  assign r1_ready = ~held1_q & ~busy;

  // Writes to x0 are accepted but never buffered
  assign set0 = r0_valid & r0_ready & (r0_addr != '0);
  assign set1 = r1_valid & r1_ready & (r1_addr != '0);

  // Grant selection: same-address pairs go oldest-first, otherwise round-robin
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!busy) begin
      if (held0_q && held1_q) begin
        if (addr0_q == addr1_q) begin
          gnt1 = r1_older_q;
          gnt0 = ~r1_older_q;
        end else begin
          gnt1 = ptr_q;
          gnt0 = ~ptr_q;
        end
      end else begin
        gnt0 = held0_q;
        gnt1 = held1_q;
      end
    end
  end

  // Write-port next state: address/data hold their value when idle
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3;
    wd3_d = wd3;
    if (clr_we) begin
      we3_d = 1'b1;
      a3_d  = clr_addr;
      wd3_d = '0;
    end else if (gnt0) begin
      we3_d = 1'b1;
      a3_d  = addr0_q;
      wd3_d = data0_q;
    end else if (gnt1) begin
      we3_d = 1'b1;
      a3_d  = addr1_q;
      wd3_d = data1_q;
    end
  end

  // Request buffers, priority pointer, age bit and registered write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held0_q    <= 1'b0;
      held1_q    <= 1'b0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
      ptr_q      <= 1'b0;
      r1_older_q <= 1'b0;
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
    end else begin
      we3 <= we3_d;
      a3  <= a3_d;
      wd3 <= wd3_d;
      if (gnt0) begin
        held0_q <= 1'b0;
      end else if (set0) begin
        held0_q <= 1'b1;
        addr0_q <= r0_addr;
        data0_q <= r0_data;
      end
      if (gnt1) begin
        held1_q <= 1'b0;
      end else if (set1) begin
        held1_q <= 1'b1;
        addr1_q <= r1_addr;
        data1_q <= r1_data;
      end
      if (gnt0) begin
        ptr_q <= 1'b1;
      end else if (gnt1) begin
        ptr_q <= 1'b0;
      end
      // Simultaneous accepts count as r0 first so the load value lands last
      if (set1) begin
        r1_older_q <= 1'b0;
      end else if (set0) begin
        r1_older_q <= held1_q & ~gnt1;
      end
    end
  end

  assign hz1 = (a1 != '0) & ((held0_q & (addr0_q == a1)) | (held1_q & (addr1_q == a1)) |
                             (we3 & (a3 == a1)));
  assign hz2 = (a2 != '0) & ((held0_q & (addr0_q == a2)) | (held1_q & (addr1_q == a2)) |
                             (we3 & (a3 == a2)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic, all
// checked cycle by cycle against a timestamp-based reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [4:0]  r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_data = '0, r1_data = '0;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  a1 = '0, a2 = '0;
  logic        hz1, hz2, busy;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
    .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2), .hz1(hz1), .hz2(hz2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes with acceptance timestamps
  logic        m_held [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_seq  [2];
  int          m_ptr;
  int          m_cyc;
  logic        m_busy;
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;

  // Observed write log
  logic [4:0]  wq_a [$];
  logic [31:0] wq_d [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held[0] = 1'b0;
    m_held[1] = 1'b0;
    m_ptr = 0;
    m_we = 1'b0;
    m_a3 = '0;
    m_wd3 = '0;
    m_cnt = 1;
`ifdef REGFILE_CLEAR_EN
    m_busy = 1'b1;
`else
    m_busy = 1'b0;
`endif
  endtask

  function automatic logic exp_hz(input logic [4:0] a);
    logic h = 1'b0;
    if (a != 5'd0) begin
      for (int k = 0; k < 2; k++) if (m_held[k] && m_addr[k] == a) h = 1'b1;
      if (m_we && m_a3 == a) h = 1'b1;
    end
    return h;
  endfunction

  // Advance the model across one rising edge using the currently driven inputs
  task automatic model_edge();
    logic       rv [2];
    logic [4:0] ra [2];
    logic [31:0] rd [2];
    logic       rdy [2];
    int g = -1;
    rv[0] = r0_valid; ra[0] = r0_addr; rd[0] = r0_data;
    rv[1] = r1_valid; ra[1] = r1_addr; rd[1] = r1_data;
    for (int k = 0; k < 2; k++) rdy[k] = !m_held[k] && !m_busy;
    if (m_busy) begin
      if (m_cnt <= 31) begin
        m_we = 1'b1;
        m_a3 = 5'(m_cnt);
        m_wd3 = '0;
        m_cnt++;
      end else begin
        m_busy = 1'b0;
        m_we = 1'b0;
      end
    end else begin
      if (m_held[0] && m_held[1]) begin
        if (m_addr[0] == m_addr[1]) g = (m_seq[0] < m_seq[1]) ? 0 : 1;
        else g = m_ptr;
      end else if (m_held[0]) g = 0;
      else if (m_held[1]) g = 1;
      if (g >= 0) begin
        m_we = 1'b1;
        m_a3 = m_addr[g];
        m_wd3 = m_data[g];
        m_held[g] = 1'b0;
        m_ptr = 1 - g;
      end else begin
        m_we = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rv[k] && rdy[k] && ra[k] != 5'd0) begin
        m_held[k] = 1'b1;
        m_addr[k] = ra[k];
        m_data[k] = rd[k];
        m_seq[k] = m_cyc * 2 + k;
      end
    end
    m_cyc++;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered ones after the edge
  task automatic step();
    @(negedge clk);
    chk("r0_ready", r0_ready, !m_held[0] && !m_busy);
    chk("r1_ready", r1_ready, !m_held[1] && !m_busy);
    chk("busy", busy, m_busy);
    chk("hz1", hz1, exp_hz(a1));
    chk("hz2", hz2, exp_hz(a2));
    model_edge();
    @(posedge clk);
    #1;
    chk("we3", we3, m_we);
    chk("a3", a3, m_a3);
    chk("wd3", wd3, m_wd3);
    if (we3 === 1'b1) begin
      wq_a.push_back(a3);
      wq_d.push_back(wd3);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] ad1, input logic [31:0] d1);
    r0_valid = v0; r0_addr = ad0; r0_data = d0;
    r1_valid = v1; r1_addr = ad1; r1_data = d1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (n) step();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [4:0] ea,
                         input logic [31:0] ed);
    if (idx < wq_a.size()) begin
      chk({tag, "_addr"}, wq_a[idx], ea);
      chk({tag, "_data"}, wq_d[idx], ed);
    end else begin
      chk({tag, "_missing"}, 64'(wq_a.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    #1;
    // Reset state
    chk("rst_we3", we3, 1'b0);
    chk("rst_a3", a3, 5'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_r0_ready", r0_ready, !m_busy);
    chk("rst_r1_ready", r1_ready, !m_busy);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Clear sequence (no-op without the clear feature)
    idle(34);
`ifdef REGFILE_CLEAR_EN
    chk("clear_count", 64'(wq_a.size()), 64'd31);
    for (int i = 0; i < 31; i++) chk_log("clear", i, 5'(i + 1), 32'd0);
`else
    chk("noclear_count", 64'(wq_a.size()), 64'd0);
`endif
    wq_a.delete(); wq_d.delete();

    // Single write with read-address hazard
    a1 = 5'd5;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    step();
    idle(3);
    chk("single_count", 64'(wq_a.size()), 64'd1);
    chk_log("single", 0, 5'd5, 32'hDEADBEEF);
    wq_a.delete(); wq_d.delete();
    a1 = 5'd0;

    // Contention with pointer at r1 (last grant was r0)
    a2 = 5'd3;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    step();
    idle(3);
    chk_log("rr_p1_first", 0, 5'd4, 32'h44);
    chk_log("rr_p1_second", 1, 5'd3, 32'h33);
    wq_a.delete(); wq_d.delete();
    // Single r1 write moves the pointer to r0
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    step();
    idle(3);
    wq_a.delete(); wq_d.delete();
    drive(1'b1, 5'd3, 32'h333, 1'b1, 5'd4, 32'h444);
    step();
    idle(3);
    chk_log("rr_p0_first", 0, 5'd3, 32'h333);
    chk_log("rr_p0_second", 1, 5'd4, 32'h444);
    wq_a.delete(); wq_d.delete();

    // Same address, same edge: r0 value first, load value last
    a1 = 5'd7;
    drive(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    step();
    idle(3);
    chk_log("same_edge_first", 0, 5'd7, 32'd1);
    chk_log("same_edge_second", 1, 5'd7, 32'd2);
    wq_a.delete(); wq_d.delete();
    // r1 accepted one edge earlier
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2);
    step();
    drive(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0);
    step();
    idle(3);
    chk_log("r1_early_first", 0, 5'd7, 32'd2);
    chk_log("r1_early_second", 1, 5'd7, 32'd1);
    wq_a.delete(); wq_d.delete();

    // Write to x0 is accepted and dropped
    a1 = 5'd0; a2 = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    step();
    idle(3);
    chk("x0_writes", 64'(wq_a.size()), 64'd0);

    // Reset while both entries are held
    drive(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_we3", we3, 1'b0);
    chk("midrst_a3", a3, 5'd0);
    chk("midrst_wd3", wd3, 32'd0);
    chk("midrst_r0_ready", r0_ready, !m_busy);
    @(posedge clk);
    #1 resetn = 1'b1;
    wq_a.delete(); wq_d.delete();
    idle(36);
`ifdef REGFILE_CLEAR_EN
    chk("midrst_writes", 64'(wq_a.size()), 64'd31);
`else
    chk("midrst_writes", 64'(wq_a.size()), 64'd0);
`endif
    wq_a.delete(); wq_d.delete();

    // Random traffic, small address space to provoke same-address pairs
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      step();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
